// File: rtl/regfile_arbiter.sv
// Two-requester round-robin controller for a tri-state register file.
// Turns req/gnt transactions into registered write-strobe and read pin sequences.
module regfile_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_i,
  input  logic             we0_i,
  input  logic [DEPTH-1:0] addr0_i,
  input  logic [WIDTH-1:0] wdata0_i,
  output logic             gnt0_o,
  output logic             rvalid0_o,
  input  logic             req1_i,
  input  logic             we1_i,
  input  logic [DEPTH-1:0] addr1_i,
  input  logic [WIDTH-1:0] wdata1_i,
  output logic             gnt1_o,
  output logic             rvalid1_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rf_cs_no,
  output logic             rf_oe_o,
  output logic             rf_ws_o,
  output logic [DEPTH-1:0] rf_addr_o,
  inout  wire  [WIDTH-1:0] rf_data_io
);

  typedef enum logic [2:0] {
    StIdle, StWSetup, StWStrobe, StWHold, StRDrive, StRCapture
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q, rdata_q;
  logic             owner_q, last_grant_q;
  logic             gnt0_q, gnt1_q, rvalid0_q, rvalid1_q;
  logic             cs_n_q, oe_q, ws_q, drive_q;

  logic             grant_valid, grant_sel, sel_we;
  logic [DEPTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (state_q == StIdle) begin
      grant_valid = req0_i | req1_i;
      // On a tie the requester that did not win last time goes next.
      if (req0_i && req1_i) grant_sel = ~last_grant_q;
      else                  grant_sel = req1_i;
    end
    sel_we    = grant_sel ? we1_i    : we0_i;
    sel_addr  = grant_sel ? addr1_i  : addr0_i;
    sel_wdata = grant_sel ? wdata1_i : wdata0_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (grant_valid) state_d = sel_we ? StWSetup : StRDrive;
      StWSetup:   state_d = StWStrobe;
      StWStrobe:  state_d = StWHold;
      StWHold:    state_d = StIdle;
      StRDrive:   state_d = StRCapture;
      StRCapture: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      oe_q         <= 1'b0;
      ws_q         <= 1'b0;
      drive_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt0_q    <= grant_valid & ~grant_sel;
      gnt1_q    <= grant_valid & grant_sel;
      rvalid0_q <= (state_q == StRCapture) & ~owner_q;
      rvalid1_q <= (state_q == StRCapture) & owner_q;
      if (grant_valid) begin
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        owner_q      <= grant_sel;
        last_grant_q <= grant_sel;
      end
      if (state_q == StRCapture) rdata_q <= rf_data_io;
      // Pins are registered from the next state so they line up with state_q.
      cs_n_q  <= (state_d == StIdle);
      oe_q    <= (state_d == StRDrive) || (state_d == StRCapture);
      ws_q    <= (state_d == StWStrobe);
      drive_q <= (state_d == StWSetup) || (state_d == StWStrobe) || (state_d == StWHold);
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rvalid0_o  = rvalid0_q;
  assign rvalid1_o  = rvalid1_q;
  assign rdata_o    = rdata_q;
  assign rf_cs_no   = cs_n_q;
  assign rf_oe_o    = oe_q;
  assign rf_ws_o    = ws_q;
  assign rf_addr_o  = addr_q;
  assign rf_data_io = drive_q ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural tri-state register file.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       rf_cs_n, rf_oe, rf_ws;
  logic [4:0] rf_addr;
  wire  [7:0] rf_data;

  logic [7:0] mem [32];
  int         ws_count = 0;
  logic [4:0] ws_addr;
  logic [7:0] ws_data;
  logic       ws_ok;

  int n_vec = 0;
  int n_bad = 0;

  regfile_arbiter #(.WIDTH(8), .DEPTH(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .rf_cs_no(rf_cs_n), .rf_oe_o(rf_oe), .rf_ws_o(rf_ws),
    .rf_addr_o(rf_addr), .rf_data_io(rf_data)
  );

  always #5 clk = ~clk;

  // Register file: stores on ws rise, drives the bus while selected and output-enabled.
  assign rf_data = (!rf_cs_n && rf_oe) ? mem[rf_addr] : 8'hzz;

  always @(posedge rf_ws) begin
    ws_count <= ws_count + 1;
    ws_addr  <= rf_addr;
    ws_data  <= rf_data;
    ws_ok    <= !rf_cs_n && !rf_oe;
    if (!rf_cs_n) mem[rf_addr] <= rf_data;
  end

  typedef struct {
    bit         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit we, input logic [4:0] a, input logic [7:0] d);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Waits (bounded) for the port's grant; drops its request in the grant cycle.
  task automatic wait_gnt(input bit port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? gnt1 : gnt0) begin
        got = 1'b1;
        break;
      end
    end
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    check("gnt_seen", got, 1);
  endtask

  task automatic run_txn(input vec_t v);
    bit got;
    int ws0;
    ws0 = ws_count;
    set_req(v.port, v.we, v.addr, v.wdata);
    wait_gnt(v.port, got);
    if (!got) return;
    check("gnt_other_low", v.port ? gnt0 : gnt1, 0);
    if (v.we) begin
      check("wsetup_pins", {rf_cs_n, rf_oe, rf_ws, rf_addr}, {3'b000, v.addr});
      @(negedge clk);
      check("wstrobe_ws", rf_ws, 1);
      @(negedge clk);
      @(negedge clk);
      check("ws_pulses", ws_count - ws0, 1);
      check("ws_addr_data_ok", {ws_ok, ws_addr, ws_data}, {1'b1, v.addr, v.wdata});
    end else begin
      check("rdrive_pins", {rf_cs_n, rf_oe, rf_ws, rf_addr}, {3'b010, v.addr});
      check("rdrive_bus", rf_data, v.exp);
      @(negedge clk);
      @(negedge clk);
      check("rvalid", {rvalid1, rvalid0}, v.port ? 2'b10 : 2'b01);
      check("rdata", rdata, v.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g[4];
    int   ng;
    bit   got;
    logic rv;
    int   ws0;

    vecs.push_back('{port: 1'b0, we: 1'b1, addr: 5'd5, wdata: 8'hA5, exp: 8'h00});
    vecs.push_back('{port: 1'b1, we: 1'b0, addr: 5'd5, wdata: 8'h00, exp: 8'hA5});
    vecs.push_back('{port: 1'b1, we: 1'b1, addr: 5'd31, wdata: 8'h0F, exp: 8'h00});
    vecs.push_back('{port: 1'b0, we: 1'b0, addr: 5'd31, wdata: 8'h00, exp: 8'h0F});
    for (int a = 0; a < 32; a++)
      vecs.push_back('{port: a[0], we: 1'b1, addr: 5'(a), wdata: 8'(a) ^ 8'h3C, exp: 8'h00});
    for (int a = 0; a < 32; a++)
      vecs.push_back('{port: ~a[0], we: 1'b0, addr: 5'(a), wdata: 8'h00,
                       exp: 8'(a) ^ 8'h3C});

    // Both requesters held from reset: grants must alternate 0,1,0,1.
    set_req(1'b0, 1'b0, 5'd1, 8'h00);
    set_req(1'b1, 1'b0, 5'd2, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("reset_pins", {rf_cs_n, rf_oe, rf_ws, rf_addr}, {3'b100, 5'd0});
    check("reset_outs", {gnt0, gnt1, rvalid0, rvalid1, rdata}, 12'h000);
    rst_n = 1'b1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt0 && ng < 4) begin g[ng] = 0; ng++; end
      if (gnt1 && ng < 4) begin g[ng] = 1; ng++; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr_count", ng, 4);
    for (int i = 0; i < 4; i++) check("rr_order", g[i], i % 2);
    repeat (4) @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset during W_SETUP: pins drop at once, no strobe, write lost.
    set_req(1'b0, 1'b1, 5'd7, 8'h5A);
    wait_gnt(1'b0, got);
    ws0 = ws_count;
    rst_n = 1'b0;
    #1;
    check("rst_wsetup_pins", {rf_cs_n, rf_oe, rf_ws, rf_addr, gnt0}, {3'b100, 5'd0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wsetup_no_ws", ws_count - ws0, 0);
    run_txn('{port: 1'b0, we: 1'b1, addr: 5'd7, wdata: 8'h77, exp: 8'h00});
    run_txn('{port: 1'b1, we: 1'b0, addr: 5'd7, wdata: 8'h00, exp: 8'h77});

    // Reset during R_DRIVE: read abandoned, no rvalid.
    set_req(1'b1, 1'b0, 5'd7, 8'h00);
    wait_gnt(1'b1, got);
    rst_n = 1'b0;
    #1;
    check("rst_rdrive_pins", {rf_cs_n, rf_oe, rf_ws, gnt1}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      rv = rv | rvalid0 | rvalid1;
    end
    check("rst_rdrive_no_rvalid", rv, 0);
    run_txn('{port: 1'b1, we: 1'b1, addr: 5'd9, wdata: 8'hC3, exp: 8'h00});
    run_txn('{port: 1'b0, we: 1'b0, addr: 5'd9, wdata: 8'h00, exp: 8'hC3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
